// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 keypad scanner: FSM states, line constants
// and the (col,row) -> hex keymap.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_t;

  localparam logic [3:0] COL_RESET = 4'b1110;
  localparam logic [3:0] ROW_IDLE  = 4'hF;

  // True when exactly one active-low line is asserted.
  function automatic logic single_low(input logic [3:0] lines);
    logic res;
    case (lines)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: res = 1'b1;
      default:                            res = 1'b0;
    endcase
    return res;
  endfunction

  function automatic logic [1:0] line_idx(input logic [3:0] lines);
    logic [1:0] res;
    case (lines)
      4'b1101: res = 2'd1;
      4'b1011: res = 2'd2;
      4'b0111: res = 2'd3;
      default: res = 2'd0;
    endcase
    return res;
  endfunction

  function automatic logic [3:0] keymap(input logic [1:0] col_idx, input logic [1:0] row_idx);
    logic [3:0] res;
    case ({row_idx, col_idx})
      4'b0000: res = 4'h1;
      4'b0001: res = 4'h2;
      4'b0010: res = 4'h3;
      4'b0011: res = 4'hA;
      4'b0100: res = 4'h4;
      4'b0101: res = 4'h5;
      4'b0110: res = 4'h6;
      4'b0111: res = 4'hB;
      4'b1000: res = 4'h7;
      4'b1001: res = 4'h8;
      4'b1010: res = 4'h9;
      4'b1011: res = 4'hC;
      4'b1100: res = 4'h0;
      4'b1101: res = 4'hF;
      4'b1110: res = 4'hE;
      default: res = 4'hD;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/keypad_col_scan.sv
// Scan tick divider and one-cold column ring. The ring rotates on tick unless
// frozen, or immediately when the decoder requests an advance.
module keypad_col_scan
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_freeze,
  input  logic       i_advance,
  output logic       o_tick_c,
  output logic [3:0] o_col
);

  localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_DIV - 1);

  logic [TICK_W-1:0] r_tick_cnt;
  logic [3:0]        r_col;
  logic              w_rotate;

  assign o_tick_c = (r_tick_cnt == TICK_LAST);
  assign w_rotate = i_advance || (o_tick_c && !i_freeze);
  assign o_col    = r_col;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tick_cnt <= '0;
      r_col      <= COL_RESET;
    end else begin
      r_tick_cnt <= o_tick_c ? '0 : r_tick_cnt + TICK_W'(1);
      if (w_rotate) begin
        r_col <= {r_col[2:0], r_col[3]};
      end
    end
  end

endmodule

// File: rtl/keypad_decoder.sv
// 4x4 matrix keypad decoder: row synchroniser, press/release debounce FSM and
// key strobe outputs. Optional auto-repeat while held: define KEYPAD_REPEAT_EN.
module keypad_decoder
  import keypad_pkg::*;
#(
  parameter int unsigned SCAN_DIV         = 100000,
  parameter int unsigned DEBOUNCE_SAMPLES = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_DLY       = 125,
  parameter int unsigned REPEAT_PER       = 25
`endif
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] row,
  output logic [3:0] col,
  output logic       key_valid,
  output logic [3:0] key_code,
  output logic       key_held
);

  localparam int unsigned CNT_W = $clog2(DEBOUNCE_SAMPLES + 1);
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SAMPLES);

  logic [3:0]       r_row_meta;
  logic [3:0]       r_row_sync;
  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [3:0]       r_cand_row;
  logic             r_key_valid;
  logic [3:0]       r_key_code;
  logic             r_key_held;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [3:0]       w_cand_nxt;
  logic             w_valid_nxt;
  logic [3:0]       w_code_nxt;
  logic             w_held_nxt;
  logic             w_tick_c;
  logic             w_freeze_c;
  logic             w_advance_c;
  logic [3:0]       w_col;
  logic             w_single_c;
  logic             w_match_c;
  logic             w_idle_c;

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned REP_MAX = (REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER;
  localparam int unsigned REP_W   = $clog2(REP_MAX + 1);

  logic [REP_W-1:0] r_rep;
  logic             r_rep_armed;
  logic [REP_W-1:0] w_rep_nxt;
  logic             w_rep_armed_nxt;
  logic [REP_W-1:0] w_rep_tgt;

  // First repeat waits REPEAT_DLY ticks, later ones REPEAT_PER ticks.
  assign w_rep_tgt = r_rep_armed ? REP_W'(REPEAT_PER) : REP_W'(REPEAT_DLY);
`endif

  keypad_col_scan #(
    .SCAN_DIV (SCAN_DIV)
  ) u_col_scan (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_freeze  (w_freeze_c),
    .i_advance (w_advance_c),
    .o_tick_c  (w_tick_c),
    .o_col     (w_col)
  );

  assign col       = w_col;
  assign key_valid = r_key_valid;
  assign key_code  = r_key_code;
  assign key_held  = r_key_held;

  assign w_single_c = single_low(r_row_sync);
  assign w_match_c  = (r_row_sync == r_cand_row);
  assign w_idle_c   = (r_row_sync == ROW_IDLE);
  assign w_cnt_inc  = (r_cnt == CNT_DONE) ? r_cnt : r_cnt + CNT_W'(1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_row_meta  <= ROW_IDLE;
      r_row_sync  <= ROW_IDLE;
      r_state     <= ST_SCAN;
      r_cnt       <= '0;
      r_cand_row  <= ROW_IDLE;
      r_key_valid <= 1'b0;
      r_key_code  <= 4'h0;
      r_key_held  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      r_rep       <= '0;
      r_rep_armed <= 1'b0;
`endif
    end else begin
      r_row_meta  <= row;
      r_row_sync  <= r_row_meta;
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_cand_row  <= w_cand_nxt;
      r_key_valid <= w_valid_nxt;
      r_key_code  <= w_code_nxt;
      r_key_held  <= w_held_nxt;
`ifdef KEYPAD_REPEAT_EN
      r_rep       <= w_rep_nxt;
      r_rep_armed <= w_rep_armed_nxt;
`endif
    end
  end

  // Next-state and output logic; rows are only sampled on scan ticks.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand_row;
    w_valid_nxt = 1'b0;
    w_code_nxt  = r_key_code;
    w_held_nxt  = r_key_held;
    w_freeze_c  = 1'b1;
    w_advance_c = 1'b0;
`ifdef KEYPAD_REPEAT_EN
    w_rep_nxt       = r_rep;
    w_rep_armed_nxt = r_rep_armed;
`endif

    case (r_state)
      ST_SCAN: begin
        // Multi-key chords read as no key, so only a single low row stops the ring.
        w_freeze_c = w_single_c;
        if (w_tick_c && w_single_c) begin
          w_cand_nxt  = r_row_sync;
          w_cnt_nxt   = CNT_W'(1);
          w_state_nxt = ST_DEBOUNCE;
        end
      end

      ST_DEBOUNCE: begin
        if (w_tick_c) begin
          if (w_match_c) begin
            if (w_cnt_inc == CNT_DONE) begin
              w_cnt_nxt   = '0;
              w_code_nxt  = keymap(line_idx(w_col), line_idx(r_cand_row));
              w_valid_nxt = 1'b1;
              w_held_nxt  = 1'b1;
              w_state_nxt = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
              w_rep_nxt       = '0;
              w_rep_armed_nxt = 1'b0;
`endif
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_SCAN;
          end
        end
      end

      ST_HELD: begin
        if (w_tick_c) begin
          if (w_idle_c) begin
            if (w_cnt_inc == CNT_DONE) begin
              w_cnt_nxt   = '0;
              w_held_nxt  = 1'b0;
              w_advance_c = 1'b1;
              w_state_nxt = ST_SCAN;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_cnt_nxt = '0;
          end
`ifdef KEYPAD_REPEAT_EN
          if (w_match_c) begin
            if (r_rep + REP_W'(1) == w_rep_tgt) begin
              w_rep_nxt       = '0;
              w_rep_armed_nxt = 1'b1;
              w_valid_nxt     = 1'b1;
            end else begin
              w_rep_nxt = r_rep + REP_W'(1);
            end
          end else begin
            w_rep_nxt       = '0;
            w_rep_armed_nxt = 1'b0;
          end
`endif
        end
      end

      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = ST_SCAN;
      end
    endcase
  end

endmodule

// File: tb/tb_keypad_decoder.sv
// Directed bench for keypad_decoder with a 4x4 matrix model driving the rows
// from the current column and a mask of pressed keys.
module tb_keypad_decoder;

  logic        clk;
  logic        rst_n;
  logic [3:0]  row;
  logic [3:0]  col;
  logic        key_valid;
  logic [3:0]  key_code;
  logic        key_held;

  logic [15:0] key_mask;   // bit index = row*4 + col
  int          strobes;
  logic [3:0]  last_code;
  int          n_total;
  int          n_bad;
  int          base;
  logic [3:0]  col_prev;

  keypad_decoder #(
    .SCAN_DIV         (8),
    .DEBOUNCE_SAMPLES (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .row       (row),
    .col       (col),
    .key_valid (key_valid),
    .key_code  (key_code),
    .key_held  (key_held)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Matrix model: a pressed key pulls its row low while its column is driven low.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        if (key_mask[r*4+c] && !col[c]) row[r] = 1'b0;
      end
    end
  end

  always @(posedge clk) begin
    if (key_valid) begin
      strobes   <= strobes + 1;
      last_code <= key_code;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_strobe(input int from, input string tag);
    int n = 0;
    while (strobes == from && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(strobes > from), 32'd1);
  endtask

  task automatic wait_release(input string tag);
    int n = 0;
    while (key_held && n < 400) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(key_held), 32'd0);
    repeat (10) @(negedge clk);
  endtask

  initial begin
    n_total   = 0;
    n_bad     = 0;
    strobes   = 0;
    last_code = 4'h0;
    key_mask  = 16'h0;
    rst_n     = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_col", 32'(col), 32'hE);
    check("rst_valid", 32'(key_valid), 32'd0);
    check("rst_code", 32'(key_code), 32'd0);
    check("rst_held", 32'(key_held), 32'd0);
    rst_n = 1'b1;

    // Idle scan: column rotates once every 8 clocks.
    repeat (7) @(posedge clk);
    #1 check("scan_c0", 32'(col), 32'hE);
    @(posedge clk);
    #1 check("scan_c1", 32'(col), 32'hD);
    repeat (8) @(posedge clk);
    #1 check("scan_c2", 32'(col), 32'hB);
    repeat (8) @(posedge clk);
    #1 check("scan_c3", 32'(col), 32'h7);
    repeat (8) @(posedge clk);
    #1 check("scan_wrap", 32'(col), 32'hE);
    check("idle_no_strobe", 32'(strobes), 32'd0);

    // Clean press of '5', then release.
    @(negedge clk);
    base = strobes;
    key_mask = 16'h0020;
    wait_strobe(base, "k5_seen");
    @(negedge clk);
    check("k5_code", 32'(last_code), 32'h5);
    check("k5_held", 32'(key_held), 32'd1);
    repeat (100) @(negedge clk);
    check("k5_single", 32'(strobes - base), 32'd1);
    key_mask = 16'h0;
    repeat (10) @(negedge clk);
    check("k5_held_debounce", 32'(key_held), 32'd1);
    wait_release("k5_release");
    col_prev = col;
    repeat (9) @(negedge clk);
    check("k5_scan_resume", 32'(col != col_prev), 32'd1);

    // Bouncy press of 'D': alternate every tick period, then settle.
    base = strobes;
    for (int i = 0; i < 8; i++) begin
      key_mask = (i % 2 == 0) ? 16'h8000 : 16'h0;
      repeat (8) @(negedge clk);
    end
    check("kD_no_bounce_strobe", 32'(strobes - base), 32'd0);
    key_mask = 16'h8000;
    wait_strobe(base, "kD_seen");
    @(negedge clk);
    check("kD_code", 32'(last_code), 32'hD);
    repeat (60) @(negedge clk);
    check("kD_single", 32'(strobes - base), 32'd1);
    key_mask = 16'h0;
    wait_release("kD_release");

    // Hold '1', add 'A' while held: no second strobe. Then 'A' alone.
    base = strobes;
    key_mask = 16'h0001;
    wait_strobe(base, "k1_seen");
    @(negedge clk);
    check("k1_code", 32'(last_code), 32'h1);
    key_mask = 16'h0009;
    repeat (100) @(negedge clk);
    check("k1A_no_extra", 32'(strobes - base), 32'd1);
    key_mask = 16'h0;
    wait_release("k1A_release");
    base = strobes;
    key_mask = 16'h0008;
    wait_strobe(base, "kA_seen");
    @(negedge clk);
    check("kA_code", 32'(last_code), 32'hA);
    key_mask = 16'h0;
    wait_release("kA_release");

    // Two keys in column 0 (rows 0 and 2): treated as no key.
    base = strobes;
    key_mask = 16'h0101;
    repeat (150) @(negedge clk);
    check("dual_no_strobe", 32'(strobes - base), 32'd0);
    check("dual_not_held", 32'(key_held), 32'd0);
    key_mask = 16'h0;
    repeat (40) @(negedge clk);

    // Reset while '7' is held, then re-detection after reset.
    base = strobes;
    key_mask = 16'h0100;
    wait_strobe(base, "k7_seen");
    @(negedge clk);
    check("k7_code", 32'(last_code), 32'h7);
    repeat (5) @(negedge clk);
    check("k7_held", 32'(key_held), 32'd1);
    rst_n = 1'b0;
    #1;
    check("k7_rst_held", 32'(key_held), 32'd0);
    check("k7_rst_code", 32'(key_code), 32'd0);
    check("k7_rst_col", 32'(col), 32'hE);
    check("k7_rst_valid", 32'(key_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    base = strobes;
    wait_strobe(base, "k7_redetect");
    @(negedge clk);
    check("k7_redetect_code", 32'(last_code), 32'h7);
    repeat (60) @(negedge clk);
    check("k7_redetect_once", 32'(strobes - base), 32'd1);
    key_mask = 16'h0;
    wait_release("k7_release");

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
